mpu_stream_ctrl: RTL and testbench

Synthesizable, parametrised memory-side load/store controller for the MPU. It moves a matrix between the memory stream and the matrix register file, LANES elements per beat, in row-major order. It generalises the single-element load/store handshake with configurable element width, matrix bounds and lane count, and adds size checking with error reporting and valid/ready backpressure on the store stream. It sits between the memory port and the matrix register file.

---
 rtl/mpu_stream_ctrl.sv | 227 ++++++++++++++++++++++
 tb/tb_mpu_stream_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mpu_stream_ctrl.sv
// Memory-side load/store controller: streams a row-major matrix between the memory
// port and the matrix register file, LANES elements per beat, with size checks.
module mpu_stream_ctrl #(
  parameter int FP              = 32,
  parameter int M               = 8,
  parameter int N               = 8,
  parameter int MATRIX_REG_SIZE = 2,
  parameter int LANES           = 2,
  parameter int MBITS           = $clog2(M),
  parameter int NBITS           = $clog2(N),
  parameter int IDXW            = $clog2(M*N)+1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       load_en,
  input  logic                       store_en,
  input  logic [MBITS:0]             mem_m_load_size,
  input  logic [NBITS:0]             mem_n_load_size,
  input  logic [MATRIX_REG_SIZE-1:0] mem_load_addr,
  input  logic [MATRIX_REG_SIZE-1:0] mem_store_addr,
  input  logic                       mem_load_valid,
  input  logic [LANES*FP-1:0]        mem_load_element,
  output logic                       mem_load_ack,
  output logic                       mem_load_error,
  output logic                       mem_store_error,
  output logic                       mem_store_en,
  output logic                       mem_store_valid,
  input  logic                       mem_store_ready,
  output logic [LANES*FP-1:0]        mem_store_element,
  output logic [LANES-1:0]           mem_store_keep,
  output logic [MBITS:0]             mem_m_store_size,
  output logic [NBITS:0]             mem_n_store_size,
  output logic                       reg_load_en,
  output logic [LANES-1:0]           reg_load_lane_en,
  output logic [MATRIX_REG_SIZE-1:0] reg_load_addr,
  output logic [IDXW-1:0]            reg_load_idx,
  output logic [LANES*FP-1:0]        reg_load_element,
  output logic [MBITS:0]             reg_m_load_size,
  output logic [NBITS:0]             reg_n_load_size,
  output logic                       reg_store_en,
  output logic [MATRIX_REG_SIZE-1:0] reg_store_addr,
  output logic [IDXW-1:0]            reg_store_idx,
  input  logic [LANES*FP-1:0]        reg_store_element,
  input  logic [MBITS:0]             reg_m_store_size,
  input  logic [NBITS:0]             reg_n_store_size
);

  localparam int SW = IDXW + 1;
  localparam logic [MBITS:0] M_MAX = (MBITS+1)'(M);
  localparam logic [NBITS:0] N_MAX = (NBITS+1)'(N);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SIZE, S_STORE, S_ERR} state_t;

  state_t                     state_q;
  logic                       load_en_q, store_en_q;
  logic [IDXW-1:0]            idx_q, total_q;
  logic [MBITS:0]             ld_m_q, st_m_q;
  logic [NBITS:0]             ld_n_q, st_n_q;
  logic [MATRIX_REG_SIZE-1:0] ld_addr_q, st_addr_q;
  logic                       ld_ack_q, ld_err_q, st_err_q, st_en_q;
  logic                       wr_en_q;
  logic [LANES-1:0]           wr_lane_q;
  logic [IDXW-1:0]            wr_idx_q;
  logic [LANES*FP-1:0]        wr_data_q;
  // Store datapath: read in flight, output register, one skid entry
  logic                       pend_q, pend_last_q;
  logic [LANES-1:0]           pend_keep_q;
  logic                       out_valid_q, out_last_q, skid_valid_q, skid_last_q;
  logic [LANES-1:0]           out_keep_q, skid_keep_q;
  logic [LANES*FP-1:0]        out_data_q, skid_data_q;

  logic            load_edge, store_edge, ld_bad, st_bad, last_beat;
  logic            st_fire, st_issue;
  logic [1:0]      st_cnt;
  logic [LANES-1:0] lane_mask;
  logic [SW-1:0]   idx_ext, tot_ext;

  assign load_edge  = load_en & ~load_en_q;
  assign store_edge = store_en & ~store_en_q;
  assign ld_bad = (mem_m_load_size == '0) || (mem_n_load_size == '0) ||
                  (mem_m_load_size > M_MAX) || (mem_n_load_size > N_MAX);
  assign st_bad = (reg_m_store_size == '0) || (reg_n_store_size == '0) ||
                  (reg_m_store_size > M_MAX) || (reg_n_store_size > N_MAX);

  assign idx_ext   = {1'b0, idx_q};
  assign tot_ext   = {1'b0, total_q};
  assign last_beat = (idx_ext + SW'(LANES)) >= tot_ext;

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    assign lane_mask[gi] = (idx_ext + SW'(gi)) < tot_ext;
  end

  // Occupancy after this cycle's handshake; a new read may land only if a slot stays free
  assign st_fire  = out_valid_q & mem_store_ready;
  assign st_cnt   = {1'b0, pend_q} + {1'b0, out_valid_q} + {1'b0, skid_valid_q} - {1'b0, st_fire};
  assign st_issue = (state_q == S_STORE) && (idx_q < total_q) && (st_cnt < 2'd2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      load_en_q <= 1'b0;     store_en_q <= 1'b0;
      idx_q <= '0;           total_q <= '0;
      ld_m_q <= '0;          ld_n_q <= '0;       st_m_q <= '0;     st_n_q <= '0;
      ld_addr_q <= '0;       st_addr_q <= '0;
      ld_ack_q <= 1'b0;      ld_err_q <= 1'b0;   st_err_q <= 1'b0; st_en_q <= 1'b0;
      wr_en_q <= 1'b0;       wr_lane_q <= '0;    wr_idx_q <= '0;   wr_data_q <= '0;
      pend_q <= 1'b0;        pend_last_q <= 1'b0; pend_keep_q <= '0;
      out_valid_q <= 1'b0;   out_last_q <= 1'b0; out_keep_q <= '0; out_data_q <= '0;
      skid_valid_q <= 1'b0;  skid_last_q <= 1'b0; skid_keep_q <= '0; skid_data_q <= '0;
    end else begin
      load_en_q   <= load_en;
      store_en_q  <= store_en;
      wr_en_q     <= 1'b0;
      wr_lane_q   <= '0;
      ld_err_q    <= 1'b0;
      st_err_q    <= 1'b0;
      pend_q      <= st_issue;
      pend_keep_q <= lane_mask;
      pend_last_q <= last_beat;
      case (state_q)
        S_IDLE: begin
          if (load_edge) begin
            ld_m_q    <= mem_m_load_size;
            ld_n_q    <= mem_n_load_size;
            ld_addr_q <= mem_load_addr;
            idx_q     <= '0;
            total_q   <= IDXW'(mem_m_load_size) * IDXW'(mem_n_load_size);
            if (ld_bad) begin
              state_q  <= S_ERR;
              ld_err_q <= 1'b1;
            end else begin
              state_q  <= S_LOAD;
              ld_ack_q <= 1'b1;
            end
          end else if (store_edge) begin
            st_addr_q <= mem_store_addr;
            state_q   <= S_SIZE;
          end
        end
        S_LOAD: begin
          if (mem_load_valid) begin
            wr_en_q   <= 1'b1;
            wr_lane_q <= lane_mask;
            wr_idx_q  <= idx_q;
            wr_data_q <= mem_load_element;
            idx_q     <= idx_q + IDXW'(LANES);
            if (last_beat) begin
              state_q  <= S_IDLE;
              ld_ack_q <= 1'b0;
            end
          end
        end
        S_SIZE: begin
          idx_q <= '0;
          if (st_bad) begin
            state_q  <= S_ERR;
            st_err_q <= 1'b1;
          end else begin
            state_q <= S_STORE;
            st_en_q <= 1'b1;
            st_m_q  <= reg_m_store_size;
            st_n_q  <= reg_n_store_size;
            total_q <= IDXW'(reg_m_store_size) * IDXW'(reg_n_store_size);
          end
        end
        S_STORE: begin
          if (st_issue) idx_q <= idx_q + IDXW'(LANES);
          if (st_fire) begin
            if (skid_valid_q) begin
              out_data_q   <= skid_data_q;
              out_keep_q   <= skid_keep_q;
              out_last_q   <= skid_last_q;
              skid_valid_q <= pend_q;
              skid_data_q  <= reg_store_element;
              skid_keep_q  <= pend_keep_q;
              skid_last_q  <= pend_last_q;
            end else begin
              out_valid_q <= pend_q;
              out_data_q  <= reg_store_element;
              out_keep_q  <= pend_keep_q;
              out_last_q  <= pend_last_q;
            end
          end else if (pend_q) begin
            if (!out_valid_q) begin
              out_valid_q <= 1'b1;
              out_data_q  <= reg_store_element;
              out_keep_q  <= pend_keep_q;
              out_last_q  <= pend_last_q;
            end else begin
              skid_valid_q <= 1'b1;
              skid_data_q  <= reg_store_element;
              skid_keep_q  <= pend_keep_q;
              skid_last_q  <= pend_last_q;
            end
          end
          if (st_fire && out_last_q) begin
            state_q <= S_IDLE;
            st_en_q <= 1'b0;
          end
        end
        S_ERR:   state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mem_load_ack      = ld_ack_q;
  assign mem_load_error    = ld_err_q;
  assign mem_store_error   = st_err_q;
  assign mem_store_en      = st_en_q;
  assign mem_store_valid   = out_valid_q;
  assign mem_store_element = out_data_q;
  assign mem_store_keep    = out_keep_q;
  assign mem_m_store_size  = st_m_q;
  assign mem_n_store_size  = st_n_q;
  assign reg_load_en       = wr_en_q;
  assign reg_load_lane_en  = wr_lane_q;
  assign reg_load_addr     = ld_addr_q;
  assign reg_load_idx      = wr_idx_q;
  assign reg_load_element  = wr_data_q;
  assign reg_m_load_size   = ld_m_q;
  assign reg_n_load_size   = ld_n_q;
  assign reg_store_en      = st_issue;
  assign reg_store_addr    = st_addr_q;
  assign reg_store_idx     = idx_q;

endmodule

// File: tb/tb_mpu_stream_ctrl.sv
// Directed bench for mpu_stream_ctrl with a small register-file model
// answering store reads one cycle after each request.
`timescale 1ns/1ps
module tb_mpu_stream_ctrl;
  localparam int FP = 32, LANES = 2, MRS = 2, IDXW = 7;

  logic              clk, rst_n;
  logic              load_en, store_en;
  logic [3:0]        mem_m_load_size, mem_n_load_size;
  logic [MRS-1:0]    mem_load_addr, mem_store_addr;
  logic              mem_load_valid;
  logic [63:0]       mem_load_element;
  logic              mem_load_ack, mem_load_error, mem_store_error, mem_store_en;
  logic              mem_store_valid, mem_store_ready;
  logic [63:0]       mem_store_element;
  logic [1:0]        mem_store_keep;
  logic [3:0]        mem_m_store_size, mem_n_store_size;
  logic              reg_load_en;
  logic [1:0]        reg_load_lane_en;
  logic [MRS-1:0]    reg_load_addr;
  logic [IDXW-1:0]   reg_load_idx;
  logic [63:0]       reg_load_element;
  logic [3:0]        reg_m_load_size, reg_n_load_size;
  logic              reg_store_en;
  logic [MRS-1:0]    reg_store_addr;
  logic [IDXW-1:0]   reg_store_idx;
  logic [63:0]       reg_store_element;
  logic [3:0]        reg_m_store_size, reg_n_store_size;

  mpu_stream_ctrl #(.FP(FP), .M(8), .N(8), .MATRIX_REG_SIZE(MRS), .LANES(LANES)) dut (
    .clk(clk), .rst_n(rst_n), .load_en(load_en), .store_en(store_en),
    .mem_m_load_size(mem_m_load_size), .mem_n_load_size(mem_n_load_size),
    .mem_load_addr(mem_load_addr), .mem_store_addr(mem_store_addr),
    .mem_load_valid(mem_load_valid), .mem_load_element(mem_load_element),
    .mem_load_ack(mem_load_ack), .mem_load_error(mem_load_error),
    .mem_store_error(mem_store_error), .mem_store_en(mem_store_en),
    .mem_store_valid(mem_store_valid), .mem_store_ready(mem_store_ready),
    .mem_store_element(mem_store_element), .mem_store_keep(mem_store_keep),
    .mem_m_store_size(mem_m_store_size), .mem_n_store_size(mem_n_store_size),
    .reg_load_en(reg_load_en), .reg_load_lane_en(reg_load_lane_en),
    .reg_load_addr(reg_load_addr), .reg_load_idx(reg_load_idx),
    .reg_load_element(reg_load_element), .reg_m_load_size(reg_m_load_size),
    .reg_n_load_size(reg_n_load_size), .reg_store_en(reg_store_en),
    .reg_store_addr(reg_store_addr), .reg_store_idx(reg_store_idx),
    .reg_store_element(reg_store_element), .reg_m_store_size(reg_m_store_size),
    .reg_n_store_size(reg_n_store_size)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int st_seen = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Register file contents: sizes per address, element value tagged by address and index
  function automatic logic [3:0] rf_m(input logic [1:0] a);
    case (a)
      2'd0:    return 4'd4;
      2'd1:    return 4'd3;
      2'd2:    return 4'd0;
      default: return 4'd2;
    endcase
  endfunction
  function automatic logic [3:0] rf_n(input logic [1:0] a);
    case (a)
      2'd0:    return 4'd4;
      2'd1:    return 4'd3;
      2'd2:    return 4'd3;
      default: return 4'd2;
    endcase
  endfunction
  function automatic logic [31:0] elem(input logic [1:0] a, input int i);
    return {4'hA, 14'h0, a, 12'(i)};
  endfunction
  function automatic logic [31:0] ld_word(input int i);
    return 32'h5000_0000 + 32'(i);
  endfunction

  always_comb begin
    reg_m_store_size = rf_m(reg_store_addr);
    reg_n_store_size = rf_n(reg_store_addr);
  end

  always @(posedge clk)
    if (reg_store_en)
      reg_store_element <= {elem(reg_store_addr, int'(reg_store_idx) + 1),
                            elem(reg_store_addr, int'(reg_store_idx))};

  always @(negedge clk)
    if (mem_store_valid) st_seen++;

  task automatic do_load(input logic [1:0] a, input int m, input int n, input int stop);
    int total = m * n;
    int beats = (total + 1) / 2;
    load_en = 1'b1; mem_load_addr = a; mem_load_valid = 1'b0;
    mem_m_load_size = 4'(m); mem_n_load_size = 4'(n);
    @(negedge clk);
    chk("ld_ack_rise", 64'(mem_load_ack), 64'd1);
    chk("ld_no_wr_yet", 64'(reg_load_en), 64'd0);
    for (int b = 0; b < beats && b < stop; b++) begin
      mem_load_valid   = 1'b1;
      mem_load_element = {ld_word(2*b+1), ld_word(2*b)};
      @(negedge clk);
      chk("ld_wen", 64'(reg_load_en), 64'd1);
      chk("ld_idx", 64'(reg_load_idx), 64'(2*b));
      chk("ld_lane", 64'(reg_load_lane_en), (2*b+1 < total) ? 64'd3 : 64'd1);
      chk("ld_data", reg_load_element, {ld_word(2*b+1), ld_word(2*b)});
      chk("ld_addr", 64'(reg_load_addr), 64'(a));
      chk("ld_dims", 64'({reg_m_load_size, reg_n_load_size}), 64'({4'(m), 4'(n)}));
      chk("ld_ack", 64'(mem_load_ack), (b < beats-1) ? 64'd1 : 64'd0);
    end
    mem_load_valid = 1'b0;
    if (stop >= beats) begin
      load_en = 1'b0;
      @(negedge clk);
      chk("ld_done_quiet", 64'({reg_load_en, mem_load_ack}), 64'd0);
    end
  endtask

  task automatic do_store(input logic [1:0] a, input bit toggle);
    int total = int'(rf_m(a)) * int'(rf_n(a));
    int beats = (total + 1) / 2;
    int b = 0;
    int cyc = 0;
    bit stalled = 1'b0;
    logic [63:0] held_d, exp_d, msk;
    logic [1:0]  held_k, exp_k;
    store_addr_set(a);
    @(negedge clk);
    chk("st_size_phase", 64'(mem_store_en), 64'd0);
    chk("st_raddr", 64'(reg_store_addr), 64'(a));
    @(negedge clk);
    chk("st_en_on", 64'(mem_store_en), 64'd1);
    chk("st_dims", 64'({mem_m_store_size, mem_n_store_size}), 64'({rf_m(a), rf_n(a)}));
    chk("st_valid_c0", 64'(mem_store_valid), 64'd0);
    @(negedge clk);
    chk("st_valid_c1", 64'(mem_store_valid), 64'd0);
    @(negedge clk);
    while (b < beats && cyc < 60) begin
      if (stalled) begin
        chk("st_hold_valid", 64'(mem_store_valid), 64'd1);
        chk("st_hold_data", mem_store_element, held_d);
        chk("st_hold_keep", 64'(mem_store_keep), 64'(held_k));
      end
      mem_store_ready = toggle ? (cyc % 2 == 0) : 1'b1;
      if (mem_store_valid) begin
        if (mem_store_ready) begin
          exp_k = (2*b+1 < total) ? 2'b11 : 2'b01;
          exp_d = {elem(a, 2*b+1), elem(a, 2*b)};
          msk   = (exp_k == 2'b11) ? '1 : 64'h0000_0000_FFFF_FFFF;
          chk("st_keep", 64'(mem_store_keep), 64'(exp_k));
          chk("st_data", mem_store_element & msk, exp_d & msk);
          b++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          held_d  = mem_store_element;
          held_k  = mem_store_keep;
        end
      end else if (!toggle) begin
        chk("st_no_bubble", 64'(mem_store_valid), 64'd1);
      end
      cyc++;
      @(negedge clk);
    end
    if (b != beats) chk("st_timeout", 64'(b), 64'(beats));
    chk("st_en_off", 64'(mem_store_en), 64'd0);
    chk("st_valid_off", 64'(mem_store_valid), 64'd0);
    store_en = 1'b0;
    mem_store_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic store_addr_set(input logic [1:0] a);
    mem_store_addr = a;
    store_en = 1'b1;
    mem_store_ready = 1'b1;
  endtask

  initial begin
    int seen0;
    rst_n = 1'b0; load_en = 1'b0; store_en = 1'b0;
    mem_m_load_size = '0; mem_n_load_size = '0; mem_load_addr = '0; mem_store_addr = '0;
    mem_load_valid = 1'b0; mem_load_element = '0; mem_store_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_outputs", 64'(|{mem_load_ack, mem_load_error, mem_store_error, mem_store_en,
        mem_store_valid, mem_store_element, mem_store_keep, reg_load_en, reg_load_lane_en,
        reg_load_idx, reg_load_element, reg_store_en, reg_store_addr, reg_store_idx}), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 3x3 load, one beat per cycle
    do_load(2'd1, 3, 3, 99);

    // m exceeds M: error pulse only
    load_en = 1'b1; mem_m_load_size = 4'd9; mem_n_load_size = 4'd3; mem_load_valid = 1'b1;
    @(negedge clk);
    chk("ld_err_pulse", 64'(mem_load_error), 64'd1);
    chk("ld_err_noack", 64'(mem_load_ack), 64'd0);
    @(negedge clk);
    chk("ld_err_width", 64'(mem_load_error), 64'd0);
    chk("ld_err_nowr", 64'({reg_load_en, mem_load_ack}), 64'd0);
    @(negedge clk);
    chk("ld_hold_norestart", 64'({reg_load_en, mem_load_ack, mem_load_error}), 64'd0);
    load_en = 1'b0; mem_load_valid = 1'b0;
    @(negedge clk);

    do_store(2'd0, 1'b0);
    do_store(2'd1, 1'b1);

    // Simultaneous edges: load wins, store edge dropped
    seen0 = st_seen;
    mem_store_addr = 2'd0; store_en = 1'b1; mem_store_ready = 1'b1;
    do_load(2'd2, 2, 2, 99);
    repeat (3) @(negedge clk);
    chk("both_no_store_en", 64'(mem_store_en), 64'd0);
    chk("both_no_beats", 64'(st_seen), 64'(seen0));
    store_en = 1'b0; mem_store_ready = 1'b0;
    @(negedge clk);

    // Zero-dimension register
    mem_store_addr = 2'd2; store_en = 1'b1;
    @(negedge clk);
    chk("st0_size_phase", 64'(mem_store_error), 64'd0);
    @(negedge clk);
    chk("st0_err_pulse", 64'(mem_store_error), 64'd1);
    chk("st0_no_en", 64'(mem_store_en), 64'd0);
    @(negedge clk);
    chk("st0_err_width", 64'(mem_store_error), 64'd0);
    chk("st0_no_read", 64'({reg_store_en, mem_store_en}), 64'd0);
    store_en = 1'b0;
    @(negedge clk);

    // Reset mid-load after two beats, then a clean load
    do_load(2'd3, 3, 3, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_outputs", 64'(|{mem_load_ack, mem_load_error, reg_load_en, reg_load_lane_en,
        reg_load_idx, reg_load_element, reg_m_load_size, reg_n_load_size, reg_load_addr,
        mem_store_en, mem_store_valid, reg_store_en}), 64'd0);
    @(negedge clk);
    load_en = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    do_load(2'd1, 2, 2, 99);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
